// File: rtl/pingpong_buf.sv
// Two-bank ping-pong buffer: the writer fills one bank while the reader drains the other, swapping on burst close.
// Optional PINGPONG_DROP_EN: writer is never stalled; words aimed at a busy bank are dropped and counted.
module pingpong_buf #(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 4,
    parameter int BURST_LEN = 16
) (
    input  logic                 wr_clk,
    input  logic                 rst_n,
    input  logic                 din_valid,
    output logic                 din_ready,
    input  logic [DATA_SIZE-1:0] din,
    input  logic                 din_last,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_last,
    output logic                 wr_bank,
    output logic                 rd_bank,
    output logic [15:0]          drop_cnt
);
    localparam int                   DEPTH      = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE-1:0] LAST_WADDR = ADDR_SIZE'(BURST_LEN - 1);
    localparam logic [ADDR_SIZE-1:0] ONE_A      = ADDR_SIZE'(1);
    localparam logic [ADDR_SIZE:0]   ONE_L      = (ADDR_SIZE + 1)'(1);

    typedef enum logic [1:0] {FREE, FILLING, FULL, DRAINING} bank_state_t;

    bank_state_t          r_state     [0:1];
    bank_state_t          w_state_nxt [0:1];
    logic [DATA_SIZE-1:0] r_mem       [0:1][0:DEPTH-1];
    logic [ADDR_SIZE:0]   r_len       [0:1];
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_bank;
    logic                 r_rd_bank;
    logic                 r_dout_valid;
    logic                 r_dout_last;
    logic [DATA_SIZE-1:0] r_dout;

    logic                 w_wr_open;
    logic                 w_wr_acc;
    logic                 w_wr_close;
    logic                 w_rd_avail;
    logic                 w_rd_load;
    logic                 w_rd_final;
    logic [ADDR_SIZE:0]   w_rd_last_idx;

    assign w_wr_open     = (r_state[r_wr_bank] == FREE) || (r_state[r_wr_bank] == FILLING);
    assign w_wr_acc      = din_valid && w_wr_open;
    assign w_wr_close    = w_wr_acc && (din_last || (r_wr_addr == LAST_WADDR));
    assign w_rd_avail    = (r_state[r_rd_bank] == FULL) || (r_state[r_rd_bank] == DRAINING);
    assign w_rd_load     = (!r_dout_valid || dout_ready) && w_rd_avail;
    assign w_rd_last_idx = r_len[r_rd_bank] - ONE_L;
    assign w_rd_final    = w_rd_load && ({1'b0, r_rd_addr} == w_rd_last_idx);

`ifdef PINGPONG_DROP_EN
    logic [15:0] r_drop_cnt;

    assign din_ready = 1'b1;
    assign drop_cnt  = r_drop_cnt;

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (din_valid && !w_wr_open && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
`else
    assign din_ready = w_wr_open;
    assign drop_cnt  = '0;
`endif

    // Writer and reader never own the same bank, so both transitions can land in one cycle.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_wr_acc && (r_wr_bank == 1'(b))) begin
                w_state_nxt[b] = w_wr_close ? FULL : FILLING;
            end
            if (w_rd_load && (r_rd_bank == 1'(b))) begin
                w_state_nxt[b] = w_rd_final ? FREE : DRAINING;
            end
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state[0] <= FREE;
            r_state[1] <= FREE;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_wr_bank <= 1'b0;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
        end else if (w_wr_acc) begin
            if (w_wr_close) begin
                r_len[r_wr_bank] <= {1'b0, r_wr_addr} + ONE_L;
                r_wr_addr        <= '0;
                r_wr_bank        <= ~r_wr_bank;
            end else begin
                r_wr_addr <= r_wr_addr + ONE_A;
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_bank][r_wr_addr] <= din;
        end
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr    <= '0;
            r_rd_bank    <= 1'b0;
            r_dout_valid <= 1'b0;
            r_dout_last  <= 1'b0;
            r_dout       <= '0;
        end else if (w_rd_load) begin
            r_dout       <= r_mem[r_rd_bank][r_rd_addr];
            r_dout_last  <= w_rd_final;
            r_dout_valid <= 1'b1;
            if (w_rd_final) begin
                r_rd_addr <= '0;
                r_rd_bank <= ~r_rd_bank;
            end else begin
                r_rd_addr <= r_rd_addr + ONE_A;
            end
        end else if (dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign dout_last  = r_dout_last;
    assign wr_bank    = r_wr_bank;
    assign rd_bank    = r_rd_bank;

endmodule
